// File: rtl/axi_tdd_ng_seq_ctrl.sv
// Profile sequencer: walks the TDD counter through a table of {frame_length, repeat}
// profiles and re-syncs the counter at every profile change.
module axi_tdd_ng_seq_ctrl #(
   parameter int PROFILE_COUNT  = 4,
   parameter int REGISTER_WIDTH = 32,
   parameter int REPEAT_WIDTH   = 16,
   parameter int PROF_AW        = (PROFILE_COUNT > 1) ? $clog2(PROFILE_COUNT) : 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      cfg_we,
   input  logic [PROF_AW-1:0]        cfg_addr,
   input  logic [REGISTER_WIDTH-1:0] cfg_frame_length,
   input  logic [REPEAT_WIDTH-1:0]   cfg_repeat,
   input  logic [PROF_AW:0]          seq_length,
   input  logic                      seq_loop,
   input  logic                      seq_start,
   input  logic                      seq_stop,
   input  logic                      tdd_endof_frame,
   output logic                      tdd_enable,
   output logic [REGISTER_WIDTH-1:0] tdd_frame_length,
   output logic                      tdd_sync,
   output logic                      seq_busy,
   output logic [PROF_AW-1:0]        seq_index,
   output logic                      seq_done
);

   typedef enum logic [2:0] {IDLE, LOAD, SYNC, RUN, DONE} state_t;

   state_t                    state_reg;
   state_t                    state_next;
   logic [REGISTER_WIDTH-1:0] len_mem [PROFILE_COUNT];
   logic [REPEAT_WIDTH-1:0]   rep_mem [PROFILE_COUNT];
   logic [PROF_AW:0]          len_lat_reg;
   logic                      loop_lat_reg;
   logic [REPEAT_WIDTH-1:0]   rep_lat_reg;
   logic [REPEAT_WIDTH-1:0]   frame_cnt_reg;
   logic [PROF_AW-1:0]        index_reg;
   logic [PROF_AW-1:0]        index_next;
   logic [REPEAT_WIDTH-1:0]   rep_eff;
   logic                      last_frame;
   logic                      last_prof;
   logic                      enable_next;
   logic                      sync_next;
   logic                      busy_next;
   logic                      done_next;

   assign rep_eff    = (rep_lat_reg == '0) ? REPEAT_WIDTH'(1) : rep_lat_reg;
   assign last_frame = (frame_cnt_reg == rep_eff - REPEAT_WIDTH'(1));
   assign last_prof  = ((PROF_AW+1)'(index_reg) + (PROF_AW+1)'(1)) >= len_lat_reg;
   assign index_next = (state_reg == IDLE || last_prof) ? '0 : index_reg + PROF_AW'(1);
   assign seq_index  = index_reg;

   always_ff @(posedge clk) begin
      if (cfg_we && (int'(cfg_addr) < PROFILE_COUNT)) begin
         len_mem[cfg_addr] <= cfg_frame_length;
         rep_mem[cfg_addr] <= cfg_repeat;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (seq_start && (seq_length != '0)) state_next = LOAD;
         LOAD: state_next = SYNC;
         SYNC: state_next = RUN;
         RUN: begin
            if (tdd_endof_frame && last_frame)
               state_next = (!last_prof || loop_lat_reg) ? LOAD : DONE;
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (seq_stop) state_next = IDLE;
   end

   // Enable holds its value through LOAD so the counter keeps running between profiles.
   always_comb begin
      sync_next   = (state_next == SYNC);
      busy_next   = (state_next != IDLE);
      done_next   = (state_next == DONE);
      enable_next = tdd_enable;
      if (state_next == SYNC)
         enable_next = 1'b1;
      else if (state_next == IDLE || state_next == DONE)
         enable_next = 1'b0;
   end

   // The table is read on the edge entering LOAD, so the new length is stable a cycle before sync.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tdd_enable       <= 1'b0;
         tdd_sync         <= 1'b0;
         seq_busy         <= 1'b0;
         seq_done         <= 1'b0;
         tdd_frame_length <= '0;
         index_reg        <= '0;
         frame_cnt_reg    <= '0;
         rep_lat_reg      <= '0;
         len_lat_reg      <= '0;
         loop_lat_reg     <= 1'b0;
      end else begin
         tdd_enable <= enable_next;
         tdd_sync   <= sync_next;
         seq_busy   <= busy_next;
         seq_done   <= done_next;
         if (state_reg == IDLE && state_next == LOAD) begin
            len_lat_reg  <= (seq_length > (PROF_AW+1)'(PROFILE_COUNT)) ?
                            (PROF_AW+1)'(PROFILE_COUNT) : seq_length;
            loop_lat_reg <= seq_loop;
         end
         if (state_next == LOAD) begin
            index_reg        <= index_next;
            tdd_frame_length <= len_mem[index_next];
            rep_lat_reg      <= rep_mem[index_next];
            frame_cnt_reg    <= '0;
         end else if (state_reg == RUN && tdd_endof_frame && !seq_stop) begin
            frame_cnt_reg <= last_frame ? '0 : frame_cnt_reg + REPEAT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_tdd_ng_seq_ctrl.sv
module tb_axi_tdd_ng_seq_ctrl;
    localparam int PC = 4;
    localparam int RW = 32;
    localparam int PW = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [RW-1:0] cfg_frame_length = '0;
    logic [PW-1:0] cfg_repeat = '0;
    logic [AW:0]   seq_length = '0;
    logic          seq_loop = 1'b0;
    logic          seq_start = 1'b0;
    logic          seq_stop = 1'b0;
    logic          tdd_endof_frame = 1'b0;
    logic          tdd_enable;
    logic [RW-1:0] tdd_frame_length;
    logic          tdd_sync;
    logic          seq_busy;
    logic [AW-1:0] seq_index;
    logic          seq_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [RW-1:0] m_len [PC];
    logic [PW-1:0] m_rep [PC];
    int            cur;
    int            remaining;
    int            eff_len;
    bit            m_loop;
    bit            m_done;
    logic [RW-1:0] exp_len;

    always #5 clk = ~clk;

    axi_tdd_ng_seq_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_frame_length (cfg_frame_length),
        .cfg_repeat       (cfg_repeat),
        .seq_length       (seq_length),
        .seq_loop         (seq_loop),
        .seq_start        (seq_start),
        .seq_stop         (seq_stop),
        .tdd_endof_frame  (tdd_endof_frame),
        .tdd_enable       (tdd_enable),
        .tdd_frame_length (tdd_frame_length),
        .tdd_sync         (tdd_sync),
        .seq_busy         (seq_busy),
        .seq_index        (seq_index),
        .seq_done         (seq_done)
    );

    function automatic int rep_eff(input logic [PW-1:0] r);
        return (r == '0) ? 1 : int'(r);
    endfunction

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [RW-1:0] l, input logic [PW-1:0] r);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_frame_length = l;
        cfg_repeat = r;
        tick();
        cfg_we = 1'b0;
        m_len[a] = l;
        m_rep[a] = r;
        $display("write  entry=%0d len=%0d rep=%0d", a, l, r);
    endtask

    task automatic start_seq(input int len, input bit loop);
        seq_length = (AW+1)'(len);
        seq_loop = loop;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        seq_length = (AW+1)'($urandom_range(0, 7));
        seq_loop = 1'($urandom_range(0, 1));
        eff_len = (len > PC) ? PC : len;
        m_loop = loop;
        m_done = 1'b0;
        cur = 0;
        n_checks++; if (seq_busy !== 1'b1) fail("start_busy", seq_busy, 1'b1);
        n_checks++; if (tdd_sync !== 1'b0) fail("start_load_sync", tdd_sync, 1'b0);
        n_checks++; if (tdd_enable !== 1'b0) fail("start_load_en", tdd_enable, 1'b0);
        n_checks++; if (seq_index !== AW'(0)) fail("start_idx", seq_index, 0);
        tick();
        exp_len = m_len[0];
        remaining = rep_eff(m_rep[0]);
        n_checks++; if (tdd_sync !== 1'b1) fail("start_sync", tdd_sync, 1'b1);
        n_checks++; if (tdd_frame_length !== exp_len) fail("start_len", tdd_frame_length, exp_len);
        n_checks++; if (tdd_enable !== 1'b1) fail("start_en", tdd_enable, 1'b1);
        tick();
        n_checks++; if (tdd_sync !== 1'b0) fail("start_sync_low", tdd_sync, 1'b0);
        n_checks++; if (tdd_enable !== 1'b1) fail("start_run_en", tdd_enable, 1'b1);
        $display("start  len=%0d loop=%0b first_len=%0d", len, loop, exp_len);
    endtask

    task automatic pulse();
        tdd_endof_frame = 1'b1;
        tick();
        tdd_endof_frame = 1'b0;
        remaining--;
        if (remaining > 0) begin
            n_checks++; if (tdd_sync !== 1'b0) fail("hold_sync", tdd_sync, 1'b0);
            n_checks++; if (tdd_enable !== 1'b1) fail("hold_en", tdd_enable, 1'b1);
            n_checks++; if (tdd_frame_length !== exp_len) fail("hold_len", tdd_frame_length, exp_len);
            n_checks++; if (seq_index !== AW'(cur)) fail("hold_idx", seq_index, cur);
            $display("eof    idx=%0d frames_left=%0d", cur, remaining);
        end else if (cur + 1 < eff_len || m_loop) begin
            cur = (cur + 1 < eff_len) ? cur + 1 : 0;
            exp_len = m_len[cur];
            remaining = rep_eff(m_rep[cur]);
            n_checks++; if (seq_index !== AW'(cur)) fail("load_idx", seq_index, cur);
            n_checks++; if (tdd_enable !== 1'b1) fail("load_en", tdd_enable, 1'b1);
            n_checks++; if (tdd_sync !== 1'b0) fail("load_sync", tdd_sync, 1'b0);
            n_checks++; if (seq_done !== 1'b0) fail("load_done", seq_done, 1'b0);
            n_checks++; if (tdd_frame_length !== exp_len) fail("load_len", tdd_frame_length, exp_len);
            tick();
            n_checks++; if (tdd_sync !== 1'b1) fail("sw_sync", tdd_sync, 1'b1);
            n_checks++; if (tdd_frame_length !== exp_len) fail("sw_len", tdd_frame_length, exp_len);
            n_checks++; if (tdd_enable !== 1'b1) fail("sw_en", tdd_enable, 1'b1);
            tick();
            n_checks++; if (tdd_sync !== 1'b0) fail("sw_sync_low", tdd_sync, 1'b0);
            $display("switch idx=%0d len=%0d", cur, exp_len);
        end else begin
            m_done = 1'b1;
            n_checks++; if (seq_done !== 1'b1) fail("done_pulse", seq_done, 1'b1);
            n_checks++; if (tdd_enable !== 1'b0) fail("done_en", tdd_enable, 1'b0);
            n_checks++; if (seq_busy !== 1'b1) fail("done_busy", seq_busy, 1'b1);
            tick();
            n_checks++; if (seq_done !== 1'b0) fail("done_clear", seq_done, 1'b0);
            n_checks++; if (seq_busy !== 1'b0) fail("done_idle", seq_busy, 1'b0);
            n_checks++; if (tdd_enable !== 1'b0) fail("done_idle_en", tdd_enable, 1'b0);
            $display("done   last_idx=%0d", cur);
        end
    endtask

    task automatic gap(input bit allow_write);
        int n;
        n = $urandom_range(0, 2);
        repeat (n) tick();
        if (allow_write && $urandom_range(0, 2) == 0)
            write_entry($urandom_range(0, PC-1), $urandom, PW'($urandom_range(0, 3)));
    endtask

    task automatic stop_seq();
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        n_checks++; if (seq_busy !== 1'b0) fail("stop_busy", seq_busy, 1'b0);
        n_checks++; if (tdd_enable !== 1'b0) fail("stop_en", tdd_enable, 1'b0);
        n_checks++; if (tdd_sync !== 1'b0) fail("stop_sync", tdd_sync, 1'b0);
        n_checks++; if (seq_done !== 1'b0) fail("stop_done", seq_done, 1'b0);
        tick();
        n_checks++; if (seq_done !== 1'b0) fail("stop_done_after", seq_done, 1'b0);
        n_checks++; if (tdd_sync !== 1'b0) fail("stop_sync_after", tdd_sync, 1'b0);
        $display("stop   at idx=%0d", cur);
    endtask

    initial begin
        #2;
        n_checks++; if (tdd_enable !== 1'b0) fail("rst_en", tdd_enable, 1'b0);
        n_checks++; if (tdd_sync !== 1'b0) fail("rst_sync", tdd_sync, 1'b0);
        n_checks++; if (tdd_frame_length !== 32'd0) fail("rst_len", tdd_frame_length, 0);
        n_checks++; if (seq_busy !== 1'b0) fail("rst_busy", seq_busy, 1'b0);
        n_checks++; if (seq_index !== AW'(0)) fail("rst_idx", seq_index, 0);
        n_checks++; if (seq_done !== 1'b0) fail("rst_done", seq_done, 1'b0);
        #10 resetn = 1'b1;
        tick();

        write_entry(0, 32'd100, 16'd2);
        write_entry(1, 32'd50, 16'd1);
        start_seq(2, 1'b0);
        n_checks++; if (tdd_frame_length !== 32'd100) fail("basic_len100", tdd_frame_length, 100);
        seq_length = 3'd1;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        n_checks++; if (tdd_sync !== 1'b0) fail("busy_start_sync", tdd_sync, 1'b0);
        n_checks++; if (seq_index !== AW'(0)) fail("busy_start_idx", seq_index, 0);
        pulse();
        pulse();
        n_checks++; if (tdd_frame_length !== 32'd50) fail("basic_len50", tdd_frame_length, 50);
        pulse();

        write_entry(0, $urandom, 16'd1);
        write_entry(1, $urandom, 16'd1);
        start_seq(2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            gap(1'b0);
            pulse();
        end
        stop_seq();

        write_entry(0, 32'd33, 16'd0);
        start_seq(1, 1'b0);
        pulse();

        for (int e = 0; e < PC; e++) write_entry(e, $urandom, 16'd1);
        start_seq(7, 1'b0);
        for (int i = 0; i < 4; i++) pulse();

        seq_length = '0;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        n_checks++; if (seq_busy !== 1'b0) fail("len0_busy", seq_busy, 1'b0);
        tick();
        n_checks++; if (seq_busy !== 1'b0) fail("len0_busy2", seq_busy, 1'b0);
        n_checks++; if (tdd_sync !== 1'b0) fail("len0_sync", tdd_sync, 1'b0);

        write_entry(0, 32'd12, 16'd1);
        start_seq(2, 1'b0);
        tdd_endof_frame = 1'b1;
        seq_stop = 1'b1;
        tick();
        tdd_endof_frame = 1'b0;
        seq_stop = 1'b0;
        n_checks++; if (seq_busy !== 1'b0) fail("prio_busy", seq_busy, 1'b0);
        n_checks++; if (tdd_enable !== 1'b0) fail("prio_en", tdd_enable, 1'b0);
        n_checks++; if (tdd_sync !== 1'b0) fail("prio_sync", tdd_sync, 1'b0);
        n_checks++; if (seq_done !== 1'b0) fail("prio_done", seq_done, 1'b0);
        tick();
        n_checks++; if (tdd_sync !== 1'b0) fail("prio_sync2", tdd_sync, 1'b0);
        n_checks++; if (seq_done !== 1'b0) fail("prio_done2", seq_done, 1'b0);

        write_entry(0, 32'd200, 16'd2);
        write_entry(1, 32'd10, 16'd1);
        start_seq(2, 1'b0);
        write_entry(1, 32'd77, 16'd1);
        pulse();
        pulse();
        n_checks++; if (tdd_frame_length !== 32'd77) fail("live_len77", tdd_frame_length, 77);
        pulse();

        start_seq(2, 1'b0);
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (tdd_enable !== 1'b0) fail("arst_en", tdd_enable, 1'b0);
        n_checks++; if (tdd_sync !== 1'b0) fail("arst_sync", tdd_sync, 1'b0);
        n_checks++; if (tdd_frame_length !== 32'd0) fail("arst_len", tdd_frame_length, 0);
        n_checks++; if (seq_busy !== 1'b0) fail("arst_busy", seq_busy, 1'b0);
        n_checks++; if (seq_index !== AW'(0)) fail("arst_idx", seq_index, 0);
        n_checks++; if (seq_done !== 1'b0) fail("arst_done", seq_done, 1'b0);
        $display("reset  asserted mid-run");
        #2 resetn = 1'b1;
        tick();
        start_seq(2, 1'b0);
        n_checks++; if (tdd_frame_length !== 32'd200) fail("arst_table_kept", tdd_frame_length, 200);
        while (!m_done) pulse();

        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < PC; e++) write_entry(e, $urandom, PW'($urandom_range(0, 3)));
            start_seq($urandom_range(1, 7), 1'b0);
            while (!m_done) begin
                gap(1'b1);
                pulse();
            end
        end
        for (int r = 0; r < 3; r++) begin
            start_seq($urandom_range(1, 7), 1'b1);
            for (int i = 0; i < 8; i++) begin
                gap(1'b1);
                pulse();
            end
            stop_seq();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
